// File: rtl/risc_trace_pkg.sv
// Shared definitions for the retire-trace buffer: FSM state encoding and record layout.
package risc_trace_pkg;

  typedef enum logic [1:0] {
    TR_IDLE    = 2'd0,
    TR_ARMED   = 2'd1,
    TR_CAPTURE = 2'd2,
    TR_FROZEN  = 2'd3
  } tr_state_e;

  localparam int TR_DATA_W     = 32;
  localparam int TR_INSTR_W    = 32;
  localparam int TR_REG_ADDR_W = 5;
  localparam int ENTRY_W       = TR_DATA_W + TR_INSTR_W + 1 + TR_REG_ADDR_W + TR_DATA_W;

  // Record layout is {pc, instr, we, rd, wdata}, MSB first.
  function automatic int entry_w(input int data_w, input int instr_w, input int reg_addr_w);
    return data_w + instr_w + 1 + reg_addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace record storage: synchronous write, asynchronous (show-ahead) read.
module trace_ram #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 102
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [ENTRY_W-1:0]       wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [ENTRY_W-1:0]       rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/risc_trace_buffer.sv
// Retire-trace capture unit: pc-match trigger, stop-on-full or wrap mode, valid/ready drain.
module risc_trace_buffer
  import risc_trace_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int INSTR_W    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 16,
  parameter int WRAP_MODE  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic                           trig_en,
  input  logic [DATA_W-1:0]              trig_pc,
  input  logic                           retire_valid,
  input  logic [DATA_W-1:0]              retire_pc,
  input  logic [INSTR_W-1:0]             retire_instr,
  input  logic                           retire_we,
  input  logic [REG_ADDR_W-1:0]          retire_rd,
  input  logic [DATA_W-1:0]              retire_wdata,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [DATA_W-1:0]              rd_pc,
  output logic [INSTR_W-1:0]             rd_instr,
  output logic                           rd_we,
  output logic [REG_ADDR_W-1:0]          rd_rd,
  output logic [DATA_W-1:0]              rd_wdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic [15:0]                    overflow_cnt,
  output logic [1:0]                     state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int EW    = entry_w(DATA_W, INSTR_W, REG_ADDR_W);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1  = CNT_W'(DEPTH - 1);

  tr_state_e         state;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       ovf;

  logic trig_hit, push, pop, is_full, drop, overwrite, wr_en, frozen_evt, ovf_inc, fill;
  logic [EW-1:0] wr_entry, rd_entry;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    trig_hit   = (state == TR_ARMED) && retire_valid && (retire_pc == trig_pc);
    push       = enable && !clear && (((state == TR_CAPTURE) && retire_valid) || trig_hit);
    pop        = rd_valid && rd_ready && !clear;
    is_full    = (cnt == DEPTH_C);
    // When full without a same-cycle pop, stop mode drops the record and wrap mode evicts the head.
    drop       = push && is_full && !pop && (WRAP_MODE == 0);
    overwrite  = push && is_full && !pop && (WRAP_MODE != 0);
    wr_en      = push && !drop;
    frozen_evt = enable && !clear && (state == TR_FROZEN) && retire_valid;
    ovf_inc    = drop || overwrite || frozen_evt;
    fill       = (WRAP_MODE == 0) && push && (((cnt == DEPTH_M1) && !pop) || drop);
  end

  assign wr_entry = {retire_pc, retire_instr, retire_we, retire_rd, retire_wdata};

  trace_ram #(
    .DEPTH   (DEPTH),
    .ENTRY_W (EW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= TR_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
    end else if (clear) begin
      state  <= enable ? (trig_en ? TR_ARMED : TR_CAPTURE) : TR_IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop || overwrite) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !overwrite && !pop) cnt <= cnt + CNT_W'(1);
      else if (pop && !wr_en) cnt <= cnt - CNT_W'(1);
      if (ovf_inc) ovf <= sat_inc16(ovf);

      if (!enable) state <= TR_IDLE;
      else begin
        case (state)
          TR_IDLE:    state <= trig_en ? TR_ARMED : TR_CAPTURE;
          TR_ARMED:   if (trig_hit) state <= fill ? TR_FROZEN : TR_CAPTURE;
          TR_CAPTURE: if (fill) state <= TR_FROZEN;
          default:    state <= TR_FROZEN;
        endcase
      end
    end
  end

  assign rd_valid     = (cnt != '0);
  assign {rd_pc, rd_instr, rd_we, rd_rd, rd_wdata} = rd_entry;
  assign count        = cnt;
  assign full         = is_full;
  assign overflow_cnt = ovf;
  assign state_o      = state;

endmodule

// File: tb/tb_risc_trace_buffer.sv
// Scoreboard bench: a stop-mode and a wrap-mode instance share one stimulus stream.
module tb_risc_trace_buffer;

  localparam int EW = 102;

  logic        clk = 1'b0;
  logic        reset, enable, clear, trig_en, retire_valid, retire_we, rd_ready;
  logic [31:0] trig_pc, retire_pc, retire_instr, retire_wdata;
  logic [4:0]  retire_rd;

  logic        v0, v1, we0, we1, f0, f1;
  logic [31:0] pc0, pc1, in0, in1, wd0, wd1;
  logic [4:0]  rd0, rd1, c0, c1;
  logic [15:0] o0, o1;
  logic [1:0]  s0, s1;

  logic [EW-1:0] q0[$], q1[$];
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  risc_trace_buffer #(.WRAP_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_we(retire_we), .retire_rd(retire_rd), .retire_wdata(retire_wdata),
    .rd_valid(v0), .rd_ready(rd_ready), .rd_pc(pc0), .rd_instr(in0), .rd_we(we0), .rd_rd(rd0),
    .rd_wdata(wd0), .count(c0), .full(f0), .overflow_cnt(o0), .state_o(s0));

  risc_trace_buffer #(.WRAP_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .trig_en(trig_en), .trig_pc(trig_pc),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_instr(retire_instr),
    .retire_we(retire_we), .retire_rd(retire_rd), .retire_wdata(retire_wdata),
    .rd_valid(v1), .rd_ready(rd_ready), .rd_pc(pc1), .rd_instr(in1), .rd_we(we1), .rd_rd(rd1),
    .rd_wdata(wd1), .count(c1), .full(f1), .overflow_cnt(o1), .state_o(s1));

  // Record i: pc=4i, rd=i+1, wdata=10(i+1), we low every third record.
  function automatic logic [EW-1:0] rec(input int i);
    logic [31:0] pc, ins, wd;
    logic [4:0]  rd;
    logic        we;
    pc  = 32'(4 * i);
    ins = 32'hA500_0000 | 32'(i);
    we  = (i % 3) != 2;
    rd  = 5'(i + 1);
    wd  = 32'(10 * (i + 1));
    return {pc, ins, we, rd, wd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic retire(input int i);
    {retire_pc, retire_instr, retire_we, retire_rd, retire_wdata} = rec(i);
    retire_valid = 1'b1;
    tick();
    retire_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    rd_ready = 1'b1;
    for (k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) tick();
    rd_ready = 1'b0;
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: left %0d/%0d expected 0/0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
  endtask

  // Monitor: a handshake completes at the next rising edge when valid and ready are both high now.
  always @(negedge clk) begin
    if (!reset && !clear && rd_ready) begin
      if (v0) begin
        n_tests++;
        if (q0.size() == 0) begin
          n_fail++;
          $display("FAIL mon0_unexpected: got pc 0x%0h expected no entry", pc0);
        end else begin
          logic [EW-1:0] e0;
          e0 = q0.pop_front();
          if ({pc0, in0, we0, rd0, wd0} !== e0) begin
            n_fail++;
            $display("FAIL mon0_entry: got 0x%0h expected 0x%0h", {pc0, in0, we0, rd0, wd0}, e0);
          end
        end
      end
      if (v1) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL mon1_unexpected: got pc 0x%0h expected no entry", pc1);
        end else begin
          logic [EW-1:0] e1;
          e1 = q1.pop_front();
          if ({pc1, in1, we1, rd1, wd1} !== e1) begin
            n_fail++;
            $display("FAIL mon1_entry: got 0x%0h expected 0x%0h", {pc1, in1, we1, rd1, wd1}, e1);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    retire_valid = 1'b0; retire_pc = '0; retire_instr = '0; retire_we = 1'b0; retire_rd = '0;
    retire_wdata = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_state", {30'd0, s0}, 32'd0);
    chk("rst_count", {27'd0, c0}, 32'd0);
    chk("rst_valid", {31'd0, v1}, 32'd0);
    chk("rst_full", {31'd0, f1}, 32'd0);
    chk("rst_ovf", {16'd0, o0}, 32'd0);

    // Basic capture, immediate start
    enable = 1'b1;
    tick();
    chk("basic_state", {30'd0, s0}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      q0.push_back(rec(i));
      q1.push_back(rec(i));
      retire(i);
      if (i == 0) chk("basic_latency_pc", pc0, 32'd0);
    end
    chk("basic_count", {27'd0, c0}, 32'd5);
    drain();
    chk("basic_count_end", {27'd0, c1}, 32'd0);

    // Trigger on pc 0x20
    enable = 1'b0;
    tick();
    chk("idle_state", {30'd0, s1}, 32'd0);
    enable = 1'b1; trig_en = 1'b1; trig_pc = 32'h20;
    tick();
    chk("armed_state", {30'd0, s0}, 32'd1);
    for (int i = 0; i <= 16; i++) begin
      if (i >= 8) begin
        q0.push_back(rec(i));
        q1.push_back(rec(i));
      end
      retire(i);
    end
    chk("trig_head_pc", pc0, 32'h20);
    chk("trig_count", {27'd0, c0}, 32'd9);
    chk("trig_state", {30'd0, s1}, 32'd2);
    drain();

    // Stop vs wrap: 20 records into 16 entries
    trig_en = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 20; i++) retire(i);
    chk("stop_count", {27'd0, c0}, 32'd16);
    chk("stop_full", {31'd0, f0}, 32'd1);
    chk("stop_state", {30'd0, s0}, 32'd3);
    chk("stop_ovf", {16'd0, o0}, 32'd4);
    chk("stop_head_pc", pc0, 32'd0);
    chk("wrap_count", {27'd0, c1}, 32'd16);
    chk("wrap_ovf", {16'd0, o1}, 32'd4);
    chk("wrap_head_pc", pc1, 32'd16);
    chk("wrap_state", {30'd0, s1}, 32'd2);
    for (int i = 0; i < 16; i++) q0.push_back(rec(i));
    for (int i = 4; i <= 20; i++) q1.push_back(rec(i));

    // Full with push and pop together
    rd_ready = 1'b1;
    retire(20);
    rd_ready = 1'b0;
    chk("wrap_pp_count", {27'd0, c1}, 32'd16);
    chk("wrap_pp_ovf", {16'd0, o1}, 32'd4);
    chk("stop_pp_count", {27'd0, c0}, 32'd15);
    chk("stop_pp_ovf", {16'd0, o0}, 32'd5);
    chk("stop_pp_state", {30'd0, s0}, 32'd3);

    // Backpressure holds the head steady
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_pc0", pc0, 32'd4);
      chk("bp_pc1", pc1, 32'd20);
    end

    // Clear flushes everything
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q0.delete();
    q1.delete();
    chk("clr_count0", {27'd0, c0}, 32'd0);
    chk("clr_ovf0", {16'd0, o0}, 32'd0);
    chk("clr_valid1", {31'd0, v1}, 32'd0);
    chk("clr_ovf1", {16'd0, o1}, 32'd0);
    chk("clr_state0", {30'd0, s0}, 32'd2);

    // Reset mid-capture
    for (int i = 0; i < 3; i++) retire(i);
    chk("pre_rst_count", {27'd0, c1}, 32'd3);
    reset = 1'b1;
    retire(3);
    reset = 1'b0;
    chk("mid_rst_state", {30'd0, s0}, 32'd0);
    chk("mid_rst_count", {27'd0, c0}, 32'd0);
    chk("mid_rst_valid", {31'd0, v1}, 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
